// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two request ports; one op in flight.
// Latency: capture WAIT_CYCLES edges after accept, min WAIT_CYCLES+2 cycles per op.
// Backpressure: ReqReady only in IDLE, response held until owner RspReady; ALU_ARBITER_ZERO_FLAG_EN adds RspZero.
module alu_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic [1:0]  ReqValid,
    output logic [1:0]  ReqReady,
    input  logic [9:0]  ReqOpcode,
    input  logic [31:0] ReqA,
    input  logic [31:0] ReqB,
    output logic [4:0]  AluOpcode,
    output logic [15:0] AluA,
    output logic [15:0] AluB,
    input  logic [15:0] AluResult,
    input  logic        AluCarry,
    input  logic        AluNegative,
    input  logic        AluOverflow,
    output logic [1:0]  RspValid,
    input  logic [1:0]  RspReady,
    output logic [15:0] RspResult,
    output logic        RspCarry,
    output logic        RspNegative,
    output logic        RspOverflow
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    ,
    output logic        RspZero
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       last_grant;
    logic       owner;
    logic [1:0] grant;
    logic       grant_port;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        grant      = 2'b00;
        grant_port = 1'b0;
        case (ReqValid)
            2'b01: begin
                grant      = 2'b01;
                grant_port = 1'b0;
            end
            2'b10: begin
                grant      = 2'b10;
                grant_port = 1'b1;
            end
            2'b11: begin
                grant_port = ~last_grant;
                grant      = last_grant ? 2'b01 : 2'b10;
            end
            default: begin
                grant      = 2'b00;
                grant_port = 1'b0;
            end
        endcase
    end

    assign ReqReady = (state == IDLE && ResetN) ? grant : 2'b00;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state       <= IDLE;
            settle_cnt  <= 4'd0;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            AluOpcode   <= 5'd0;
            AluA        <= 16'd0;
            AluB        <= 16'd0;
            RspValid    <= 2'b00;
            RspResult   <= 16'd0;
            RspCarry    <= 1'b0;
            RspNegative <= 1'b0;
            RspOverflow <= 1'b0;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
            RspZero     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|ReqValid) begin
                        AluOpcode  <= grant_port ? ReqOpcode[9:5]  : ReqOpcode[4:0];
                        AluA       <= grant_port ? ReqA[31:16]     : ReqA[15:0];
                        AluB       <= grant_port ? ReqB[31:16]     : ReqB[15:0];
                        owner      <= grant_port;
                        last_grant <= grant_port;
                        settle_cnt <= WAIT_LOAD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        RspResult   <= AluResult;
                        RspCarry    <= AluCarry;
                        RspNegative <= AluNegative;
                        RspOverflow <= AluOverflow;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
                        RspZero     <= (AluResult == 16'h0000);
`endif
                        RspValid    <= owner ? 2'b10 : 2'b01;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    // Only the owning port's ready completes the response.
                    if (RspReady[owner]) begin
                        RspValid <= 2'b00;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model with per-cycle compare, plus directed literal checks.
module tb_alu_arbiter;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic [1:0]  ReqValid, ReqReady, RspValid, RspReady;
    logic [9:0]  ReqOpcode;
    logic [31:0] ReqA, ReqB;
    logic [4:0]  AluOpcode;
    logic [15:0] AluA, AluB, AluResult, RspResult;
    logic        AluCarry, AluNegative, AluOverflow;
    logic        RspCarry, RspNegative, RspOverflow;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    logic        RspZero;
`endif

    // Second instance with a longer settle window, driven directly.
    logic [1:0]  d4_req_valid, d4_req_ready, d4_rsp_valid, d4_rsp_ready;
    logic [9:0]  d4_opcode;
    logic [31:0] d4_a, d4_b;
    logic [4:0]  d4_alu_op;
    logic [15:0] d4_alu_a, d4_alu_b, d4_alu_result, d4_rsp_result;
    logic        d4_rsp_carry, d4_rsp_negative, d4_rsp_overflow;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    logic        d4_rsp_zero;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 Clock = ~Clock;

    // Reference ALU: returns {overflow, negative, carry, result}.
    function automatic logic [18:0] alu_fn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c, v;
        s = 17'd0; r = 16'd0; c = 1'b0; v = 1'b0;
        case (op)
            5'h01: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0]; c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            5'h02: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[15:0]; c = s[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            5'h03: r = a & b;
            5'h04: r = a ^ b;
            default: r = 16'h0000;
        endcase
        return {v, r[15], c, r};
    endfunction

    logic [18:0] alu_out;
    assign alu_out     = alu_fn(AluOpcode, AluA, AluB);
    assign AluResult   = alu_out[15:0];
    assign AluCarry    = alu_out[16];
    assign AluNegative = alu_out[17];
    assign AluOverflow = alu_out[18];

    alu_arbiter #(.WAIT_CYCLES(1)) u_dut (
        .Clock(Clock), .ResetN(ResetN),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOpcode(ReqOpcode), .ReqA(ReqA), .ReqB(ReqB),
        .AluOpcode(AluOpcode), .AluA(AluA), .AluB(AluB),
        .AluResult(AluResult), .AluCarry(AluCarry),
        .AluNegative(AluNegative), .AluOverflow(AluOverflow),
        .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult),
        .RspCarry(RspCarry), .RspNegative(RspNegative), .RspOverflow(RspOverflow)
`ifdef ALU_ARBITER_ZERO_FLAG_EN
        , .RspZero(RspZero)
`endif
    );

    alu_arbiter #(.WAIT_CYCLES(4)) u_dut4 (
        .Clock(Clock), .ResetN(ResetN),
        .ReqValid(d4_req_valid), .ReqReady(d4_req_ready),
        .ReqOpcode(d4_opcode), .ReqA(d4_a), .ReqB(d4_b),
        .AluOpcode(d4_alu_op), .AluA(d4_alu_a), .AluB(d4_alu_b),
        .AluResult(d4_alu_result), .AluCarry(1'b0),
        .AluNegative(1'b0), .AluOverflow(1'b0),
        .RspValid(d4_rsp_valid), .RspReady(d4_rsp_ready), .RspResult(d4_rsp_result),
        .RspCarry(d4_rsp_carry), .RspNegative(d4_rsp_negative), .RspOverflow(d4_rsp_overflow)
`ifdef ALU_ARBITER_ZERO_FLAG_EN
        , .RspZero(d4_rsp_zero)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 0 : 1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return -1;
    endfunction

    // Transaction model: an op is either absent, settling (edges counted since accept), or awaiting response.
    localparam int MW = 1;
    bit          m_busy, m_resp, m_last, m_owner;
    int          m_edges;
    logic [4:0]  m_op;
    logic [15:0] m_a, m_b, m_res;
    logic        m_c, m_n, m_v, m_z;
    logic [18:0] m_tmp;
    int          m_w;

    always @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            m_busy = 0; m_resp = 0; m_last = 1; m_owner = 0; m_edges = 0;
            m_op = '0; m_a = '0; m_b = '0; m_res = '0;
            m_c = 0; m_n = 0; m_v = 0; m_z = 0;
        end else if (!m_busy) begin
            m_w = winner(ReqValid, m_last);
            if (m_w >= 0) begin
                m_busy  = 1; m_resp = 0; m_edges = 0;
                m_owner = (m_w == 1); m_last = m_owner;
                m_op = ReqOpcode[m_w*5 +: 5];
                m_a  = ReqA[m_w*16 +: 16];
                m_b  = ReqB[m_w*16 +: 16];
            end
        end else if (!m_resp) begin
            m_edges++;
            if (m_edges == MW) begin
                m_tmp = alu_fn(m_op, m_a, m_b);
                m_res = m_tmp[15:0]; m_c = m_tmp[16]; m_n = m_tmp[17]; m_v = m_tmp[18];
                m_z = (m_res == 16'h0000);
                m_resp = 1;
            end
        end else if (RspReady[m_owner]) begin
            m_busy = 0; m_resp = 0;
        end
    end

    int         c_w;
    logic [1:0] c_rdy, c_rv;
    always @(negedge Clock) begin
        if (ResetN === 1'b1) begin
            c_w   = winner(ReqValid, m_last);
            c_rdy = (!m_busy && c_w >= 0) ? ((c_w == 1) ? 2'b10 : 2'b01) : 2'b00;
            c_rv  = (m_busy && m_resp) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("cmp_req_ready", 32'(ReqReady), 32'(c_rdy));
            chk("cmp_rsp_valid", 32'(RspValid), 32'(c_rv));
            chk("cmp_alu_op", 32'(AluOpcode), 32'(m_op));
            chk("cmp_alu_a", 32'(AluA), 32'(m_a));
            chk("cmp_alu_b", 32'(AluB), 32'(m_b));
            chk("cmp_rsp_result", 32'(RspResult), 32'(m_res));
            chk("cmp_rsp_flags", 32'({RspCarry, RspNegative, RspOverflow}), 32'({m_c, m_n, m_v}));
`ifdef ALU_ARBITER_ZERO_FLAG_EN
            chk("cmp_rsp_zero", 32'(RspZero), 32'(m_z));
`endif
        end
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic set_port(input int p, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        ReqOpcode[p*5 +: 5] = op;
        ReqA[p*16 +: 16]    = a;
        ReqB[p*16 +: 16]    = b;
    endtask

    task automatic apply_reset();
        ResetN = 1'b0;
        tick();
        tick();
        ResetN = 1'b1;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (RspValid == 2'b00 && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (RspValid == 2'b00) begin
            checks++;
            fails++;
            $display("FAIL rsp_timeout: got no response within %0d cycles", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] rsp_q[4];
    int         rsp_t[4];
    int         nrsp;

    initial begin
        ResetN = 1'b0;
        ReqValid = 2'b11; RspReady = 2'b00;
        ReqOpcode = '0; ReqA = '0; ReqB = '0;
        d4_req_valid = 2'b00; d4_rsp_ready = 2'b00;
        d4_opcode = '0; d4_a = '0; d4_b = '0; d4_alu_result = 16'h0000;
        #1;
        chk("reset_req_ready", 32'(ReqReady), 32'h0);
        chk("reset_rsp_valid", 32'(RspValid), 32'h0);
        chk("reset_alu_a", 32'(AluA), 32'h0);
        chk("reset_rsp_result", 32'(RspResult), 32'h0);
        ReqValid = 2'b00;
        tick();
        tick();
        ResetN = 1'b1;

        // Single port0 add.
        set_port(0, 5'h01, 16'h0003, 16'h0004);
        ReqValid = 2'b01;
        #1 chk("t1_req_ready", 32'(ReqReady), 32'h1);
        tick();
        ReqValid = 2'b00;
        #1 chk("t1_alu_a", 32'(AluA), 32'h3);
        chk("t1_settle_no_rsp", 32'(RspValid), 32'h0);
        tick();
        RspReady = 2'b01;
        #1 chk("t1_rsp_valid", 32'(RspValid), 32'h1);
        chk("t1_rsp_result", 32'(RspResult), 32'h7);
        tick();
        RspReady = 2'b00;
        #1 chk("t1_rsp_done", 32'(RspValid), 32'h0);

        // Both ports continuously: alternation from port0, 3 cycles per op.
        apply_reset();
        set_port(0, 5'h01, 16'd10, 16'd20);
        set_port(1, 5'h02, 16'd100, 16'd1);
        ReqValid = 2'b11; RspReady = 2'b11; nrsp = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            #1;
            if (RspValid != 2'b00 && nrsp < 4) begin
                rsp_q[nrsp] = RspValid;
                rsp_t[nrsp] = i;
                nrsp++;
            end
        end
        chk("t2_nrsp", 32'(nrsp), 32'd4);
        chk("t2_grant0", 32'(rsp_q[0]), 32'h1);
        chk("t2_grant1", 32'(rsp_q[1]), 32'h2);
        chk("t2_grant2", 32'(rsp_q[2]), 32'h1);
        chk("t2_grant3", 32'(rsp_q[3]), 32'h2);
        for (int k = 0; k < 3; k++) chk("t2_period", 32'(rsp_t[k+1] - rsp_t[k]), 32'd3);
        ReqValid = 2'b00;
        repeat (3) tick();

        // Port1 response held off, non-owner ready ignored.
        RspReady = 2'b00;
        set_port(1, 5'h03, 16'hF0F0, 16'hFF00);
        ReqValid = 2'b10;
        #1 chk("t3_req_ready", 32'(ReqReady), 32'h2);
        tick();
        ReqValid = 2'b00;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3_hold_valid", 32'(RspValid), 32'h2);
            chk("t3_hold_result", 32'(RspResult), 32'hF000);
            tick();
        end
        RspReady = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 chk("t3_wrong_ready", 32'(RspValid), 32'h2);
        end
        RspReady = 2'b10;
        tick();
        RspReady = 2'b00;
        #1 chk("t3_done", 32'(RspValid), 32'h0);

        // Reset during SETTLE.
        set_port(0, 5'h01, 16'h0005, 16'h0006);
        set_port(1, 5'h01, 16'h0007, 16'h0008);
        ReqValid = 2'b01;
        tick();
        ReqValid = 2'b11;
        ResetN = 1'b0;
        #1 chk("t4_rst_req_ready", 32'(ReqReady), 32'h0);
        chk("t4_rst_rsp_valid", 32'(RspValid), 32'h0);
        chk("t4_rst_alu", 32'({AluOpcode, AluA, AluB}), 32'h0);
        chk("t4_rst_result", 32'(RspResult), 32'h0);
        chk("t4_rst_flags", 32'({RspCarry, RspNegative, RspOverflow}), 32'h0);
        tick();
        ResetN = 1'b1;
        #1 chk("t4_tie_ready", 32'(ReqReady), 32'h1);
        tick();
        ReqValid = 2'b00;
        RspReady = 2'b11;
        #1 chk("t4_tie_alu_a", 32'(AluA), 32'h5);
        repeat (3) tick();

        // Signed overflow add producing zero, then a borrowing subtract.
        RspReady = 2'b00;
        set_port(0, 5'h01, 16'h8000, 16'h8000);
        ReqValid = 2'b01;
        tick();
        ReqValid = 2'b00;
        wait_rsp();
        chk("t5_result", 32'(RspResult), 32'h0);
        chk("t5_carry", 32'(RspCarry), 32'h1);
        chk("t5_overflow", 32'(RspOverflow), 32'h1);
        chk("t5_negative", 32'(RspNegative), 32'h0);
`ifdef ALU_ARBITER_ZERO_FLAG_EN
        chk("t5_zero", 32'(RspZero), 32'h1);
`endif
        RspReady = 2'b01;
        tick();
        set_port(0, 5'h02, 16'h0001, 16'h0002);
        ReqValid = 2'b01;
        tick();
        ReqValid = 2'b00;
        wait_rsp();
        chk("t5_sub_result", 32'(RspResult), 32'hFFFF);
        chk("t5_sub_flags", 32'({RspCarry, RspNegative, RspOverflow}), 32'b110);
`ifdef ALU_ARBITER_ZERO_FLAG_EN
        chk("t5_sub_zero", 32'(RspZero), 32'h0);
`endif
        tick();
        RspReady = 2'b00;

        // Four-cycle settle: the value present at the 4th edge after accept is captured.
        d4_opcode = 10'h001; d4_a = 32'h0000_1234; d4_b = 32'h0000_0001;
        d4_req_valid = 2'b01;
        #1 chk("t6_req_ready", 32'(d4_req_ready), 32'h1);
        tick();
        d4_req_valid = 2'b00;
        d4_alu_result = 16'h1111;
        #1 chk("t6_alu_a", 32'(d4_alu_a), 32'h1234);
        tick();
        d4_alu_result = 16'h2222;
        tick();
        tick();
        d4_alu_result = 16'h4444;
        #1 chk("t6_not_yet", 32'(d4_rsp_valid), 32'h0);
        tick();
        d4_alu_result = 16'h5555;
        d4_rsp_ready = 2'b01;
        #1 chk("t6_rsp_valid", 32'(d4_rsp_valid), 32'h1);
        chk("t6_rsp_result", 32'(d4_rsp_result), 32'h4444);
        chk("t6_rsp_flags", 32'({d4_rsp_carry, d4_rsp_negative, d4_rsp_overflow}), 32'h0);
`ifdef ALU_ARBITER_ZERO_FLAG_EN
        chk("t6_rsp_zero", 32'(d4_rsp_zero), 32'h0);
`endif
        tick();
        d4_rsp_ready = 2'b00;
        #1 chk("t6_done", 32'(d4_rsp_valid), 32'h0);
        chk("t6_result_kept", 32'(d4_rsp_result), 32'h4444);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
